// File: rtl/subneg_prog_loader.sv
// Framed program loader for the 6-bit subneg core: length, data words, checksum.
// Data words go into core memory through one write port; the core is released only after a good checksum.
module subneg_prog_loader #(
  parameter int DEPTH = 22,
  parameter int WIDTH = 6,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             reload,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             core_run,
  output logic             load_done,
  output logic             error,
  output logic [WIDTH-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, DATA, CHECK, RUN, ERR} state_t;

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  state_t          state, next_state;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   last;
  logic            accept;
  logic            len_ok;

  assign in_ready = (state == IDLE) || (state == DATA) || (state == CHECK);
  assign accept   = in_valid & in_ready;
  assign len_ok   = (in_data != '0) && (in_data <= DEPTH_W);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = len_ok ? DATA : ERR;
      DATA:    if (accept && (cnt == last)) next_state = CHECK;
      CHECK:   if (accept) next_state = (in_data == checksum) ? RUN : ERR;
      RUN,
      ERR:     if (reload) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Storing N-1 rather than N keeps the counter compare within AW bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      last      <= '0;
      checksum  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_run  <= 1'b0;
      load_done <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      core_run  <= (next_state == RUN);
      load_done <= (next_state == RUN);
      error     <= (next_state == ERR);
      if (accept) begin
        case (state)
          IDLE: begin
            if (len_ok) begin
              last     <= AW'(in_data - WIDTH'(1));
              cnt      <= '0;
              checksum <= '0;
            end
          end
          DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt;
            mem_wdata <= in_data;
            checksum  <= checksum + in_data;
            if (cnt != last) cnt <= cnt + AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_subneg_prog_loader.sv
// Directed bench for subneg_prog_loader; memory writes are checked against a scoreboard queue
// filled as data words are driven, status outputs against bench-computed values.
module tb_subneg_prog_loader;

  typedef struct packed {
    logic [4:0] addr;
    logic [5:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [5:0] in_data;
  logic       in_ready;
  logic       reload;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [5:0] mem_wdata;
  logic       core_run;
  logic       load_done;
  logic       error;
  logic [5:0] checksum;

  int   vectors = 0;
  int   miscompares = 0;
  wr_t  exp_q[$];
  logic [5:0] data_q[$];

  subneg_prog_loader #(.DEPTH(22), .WIDTH(6), .AW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_run  (core_run),
    .load_done (load_done),
    .error     (error),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Any write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checkOutput("spurious_write", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        wr_t w;
        w = exp_q.pop_front();
        checkOutput("mem_addr", 32'(mem_addr), 32'(w.addr));
        checkOutput("mem_wdata", 32'(mem_wdata), 32'(w.data));
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] word, input int gap);
    int budget;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = word;
    budget   = 20;
    while (!in_ready && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (in_ready) begin
      @(posedge clk);
      #1;
    end else begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic send_frame(input int n, input logic [5:0] cks, input int max_gap);
    applyStimulus(6'(n), 0);
    if (n >= 1 && n <= 22) begin
      for (int k = 0; k < n; k++) begin
        exp_q.push_back('{addr: 5'(k), data: data_q[k]});
        applyStimulus(data_q[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      end
      applyStimulus(cks, 0);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [5:0] sum_q();
    logic [5:0] s = '0;
    foreach (data_q[i]) s = s + data_q[i];
    return s;
  endfunction

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    checkOutput("reload_core_run", 32'(core_run), 32'd0);
    checkOutput("reload_error", 32'(error), 32'd0);
    checkOutput("reload_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_run(input string tag, input logic [5:0] cks);
    checkOutput({tag, "_core_run"}, 32'(core_run), 32'd1);
    checkOutput({tag, "_load_done"}, 32'(load_done), 32'd1);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_checksum"}, 32'(checksum), 32'(cks));
  endtask

  initial begin
    logic [5:0] cks;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    reload   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_core_run", 32'(core_run), 32'd0);
    checkOutput("rst_load_done", 32'(load_done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_checksum", 32'(checksum), 32'd0);
    reset = 1'b0;

    // Three-word frame, back-to-back.
    data_q = '{6'd18, 6'd18, 6'd3};
    send_frame(3, 6'd39, 0);
    check_run("f3", 6'd39);
    pulse_reload();

    // Checksum wraps modulo 64.
    data_q = '{6'd60, 6'd10};
    send_frame(2, 6'd6, 0);
    check_run("wrap", 6'd6);
    pulse_reload();

    // Bad checksum, then words offered in ERR must not be consumed.
    data_q = '{6'd1, 6'd1};
    send_frame(2, 6'd5, 0);
    checkOutput("bad_error", 32'(error), 32'd1);
    checkOutput("bad_core_run", 32'(core_run), 32'd0);
    checkOutput("bad_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bad_checksum", 32'(checksum), 32'd2);
    in_valid = 1'b1;
    in_data  = 6'd7;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("err_hold", 32'(error), 32'd1);
    pulse_reload();

    // Illegal lengths.
    send_frame(0, 6'd0, 0);
    checkOutput("len0_error", 32'(error), 32'd1);
    pulse_reload();
    send_frame(23, 6'd0, 0);
    checkOutput("len23_error", 32'(error), 32'd1);
    pulse_reload();

    // Full-depth frame with random stalls.
    data_q.delete();
    for (int k = 0; k < 22; k++) data_q.push_back(6'($urandom_range(0, 63)));
    cks = sum_q();
    send_frame(22, cks, 2);
    check_run("full", cks);
    checkOutput("full_last_addr", 32'(mem_addr), 32'd21);
    pulse_reload();

    // Reset after two of five data words, then a clean frame.
    data_q = '{6'd9, 6'd33, 6'd4, 6'd50, 6'd12};
    applyStimulus(6'd5, 0);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{addr: 5'(k), data: data_q[k]});
      applyStimulus(data_q[k], int'($urandom_range(0, 2)));
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_checksum", 32'(checksum), 32'd0);
    checkOutput("midrst_error", 32'(error), 32'd0);
    checkOutput("midrst_core_run", 32'(core_run), 32'd0);
    data_q = '{6'd11, 6'd22, 6'd33, 6'd44};
    send_frame(4, 6'd46, 0);
    check_run("after_rst", 6'd46);

    // Reset beats reload.
    reset  = 1'b1;
    reload = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    reload = 1'b0;
    checkOutput("rst_reload_core_run", 32'(core_run), 32'd0);
    checkOutput("rst_reload_checksum", 32'(checksum), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("writes_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
